stream_arb2: RTL and testbench
==============================

Name: stream_arb2

Overview:
- Two-input round-robin packet arbiter with valid/ready handshake and a registered one-entry output stage.
- Sits directly upstream of mux2to1 and drives its select input `s`; combinationally `sel` is 0 for in0 and 1 for in1.
- Holds a grant for a whole packet, so beats from the two sources never interleave.
- Implemented in RTL and synthesized with the team's qflow flow.

Parameters:
- WIDTH, 8, data bits per beat on each input and on the output.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in0_valid  input  1  source 0 has a beat
- in0_data  input  WIDTH  source 0 beat data
- in0_last  input  1  beat is the final beat of its packet
- in0_ready  output  1  source 0 beat accepted this cycle when high with in0_valid
- in1_valid  input  1  source 1 has a beat
- in1_data  input  WIDTH  source 1 beat data
- in1_last  input  1  final beat of packet
- in1_ready  output  1  source 1 accept
- out_valid  output  1  registered output beat present
- out_data  output  WIDTH  registered output data
- out_last  output  1  registered last flag
- out_ready  input  1  downstream accept
- sel  output  1  current/most recent grant (0 = in0, 1 = in1); drives mux2to1 `s`

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - state=IDLE, out_valid=0, out_data=0, out_last=0, sel=0.
  - last_served=1, so in0 wins the first tie.
  - in0_ready=in1_ready=0.
- Reset mid-packet drops the partial packet and any buffered beat. There is no recovery state.
- States:
  - IDLE: both readies 0. Next state:
    - only in0_valid -> GRANT0
    - only in1_valid -> GRANT1
    - both valid -> grant the index != last_served
    - neither -> stay IDLE
  - GRANT0 / GRANT1: sel=0 / 1 is registered on entry. On entry last_served updates to the granted index.
- Accept condition:
  - slot_free = !out_valid | out_ready.
  - inX_ready = (state==GRANTX) & slot_free; the non-granted ready is 0.
  - A beat transfers when inX_valid & inX_ready.
- Output register:
  - On a transfer, out_data/out_last load the granted input's beat and out_valid <= 1.
  - Otherwise, if out_ready, out_valid <= 0.
  - out_data/out_last hold their value while out_valid=1 & out_ready=0.
- Packet end: a transfer with last=1 moves to IDLE the next cycle. There is exactly one IDLE cycle between packets, even when the other source is waiting.
- Latency:
  - A request arriving in IDLE at cycle N gives the grant at N+1 and the first transfer at N+1 if slot_free.
  - out_valid rises at N+2.
  - Sustained throughput is 1 beat/cycle within a packet while out_ready=1.
- sel changes only on IDLE->GRANTx and holds through IDLE, so the mux output is glitch-free around packet boundaries.
- Invalid input during a grant (valid drops mid-packet): the grant is held and nothing transfers. There is no timeout.
- Input data/last are only sampled on a transfer.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_GRANT0=2'd1, ST_GRANT1=2'd2 (2'd3 unreachable; decodes to IDLE).
  - the SEL_IN0=1'b0 / SEL_IN1=1'b1 constants shared with the mux2to1 integration.
- One natural sub-module: stream_outreg (WIDTH+1-bit single-entry output register with valid/ready). The arbiter FSM stays in the top.

Test Plan:
- Reset: after rst_n low then high with no inputs -> out_valid=0, sel=0, both readies 0 for 10 cycles.
- Single source: in1 sends 3-beat packet 0xA1,0xA2,0xA3 (last on 0xA3) with out_ready=1 -> sel=1 from cycle 1, out_data A1,A2,A3 on cycles 2..4, out_last only with A3, then IDLE.
- Tie: both valid from reset with 2-beat packets 0x10,0x11 / 0x20,0x21 -> in0 packet first, one IDLE cycle, then in1 packet. A second simultaneous pair of packets -> in0 again (alternation).
- Backpressure: out_ready=0 for 4 cycles mid-packet -> out_data holds, in ready=0, no beat lost or duplicated; 0x55,0x66,0x77 emerge in order.
- No interleave: in1 asserts valid during in0's 4-beat packet -> in1_ready stays 0 until in0's last beat transfers, then in1 is granted.
- Async reset mid-packet: rst_n pulsed low between clock edges during beat 2 -> outputs clear immediately; after release the next packet is arbitrated from IDLE with in0 priority.

Source files
------------

// File: rtl/stream_arb2_pkg.sv
// Shared definitions for the two-input round-robin packet arbiter and its
// mux2to1 select integration.
package stream_arb2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT0 = 2'd1,
      ST_GRANT1 = 2'd2
   } state_e;

   localparam logic SEL_IN0 = 1'b0;
   localparam logic SEL_IN1 = 1'b1;

endpackage

// File: rtl/stream_outreg.sv
// Single-entry registered output stage with valid/ready; accepts a new entry
// whenever it is empty or being drained in the same cycle.
module stream_outreg #(
   parameter int unsigned WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             out_valid_o,
   output logic [WIDTH-1:0] out_data_o,
   input  logic             out_ready_i
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;

   always_comb begin
      in_ready_o = !valid_q || out_ready_i;
      valid_d    = valid_q;
      data_d     = data_q;
      if (in_valid_i && in_ready_o) begin
         valid_d = 1'b1;
         data_d  = in_data_i;
      end else if (out_ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid_o = valid_q;
   assign out_data_o  = data_q;

endmodule

// File: rtl/stream_arb2.sv
// Two-input round-robin packet arbiter: holds a grant for a whole packet and
// feeds a registered one-entry output stage; sel drives the downstream mux.
module stream_arb2
   import stream_arb2_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in0_valid,
   input  logic [WIDTH-1:0] in0_data,
   input  logic             in0_last,
   output logic             in0_ready,
   input  logic             in1_valid,
   input  logic [WIDTH-1:0] in1_data,
   input  logic             in1_last,
   output logic             in1_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   input  logic             out_ready,
   output logic             sel
);

   state_e         state_q, state_d;
   logic           sel_q, sel_d;
   logic           last_served_q, last_served_d;
   logic           slot_free;
   logic           grant0, grant1;
   logic           grant_valid;
   logic           xfer;
   logic [WIDTH:0] grant_beat;
   logic [WIDTH:0] out_beat;

   always_comb begin
      state_d       = state_q;
      sel_d         = sel_q;
      last_served_d = last_served_q;
      grant0        = (state_q == ST_GRANT0);
      grant1        = (state_q == ST_GRANT1);
      in0_ready     = grant0 && slot_free;
      in1_ready     = grant1 && slot_free;
      grant_valid   = (grant0 && in0_valid) || (grant1 && in1_valid);
      grant_beat    = grant1 ? {in1_last, in1_data} : {in0_last, in0_data};
      xfer          = grant_valid && slot_free;

      case (state_q)
         ST_GRANT0, ST_GRANT1: begin
            if (xfer && grant_beat[WIDTH]) begin
               state_d = ST_IDLE;
            end
         end
         // Unused encoding behaves as IDLE.
         default: begin
            if (in0_valid && (!in1_valid || last_served_q == SEL_IN1)) begin
               state_d       = ST_GRANT0;
               sel_d         = SEL_IN0;
               last_served_d = SEL_IN0;
            end else if (in1_valid) begin
               state_d       = ST_GRANT1;
               sel_d         = SEL_IN1;
               last_served_d = SEL_IN1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         sel_q         <= SEL_IN0;
         last_served_q <= SEL_IN1;
      end else begin
         state_q       <= state_d;
         sel_q         <= sel_d;
         last_served_q <= last_served_d;
      end
   end

   stream_outreg #(
      .WIDTH (WIDTH + 1)
   ) u_outreg (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (grant_valid),
      .in_ready_o  (slot_free),
      .in_data_i   (grant_beat),
      .out_valid_o (out_valid),
      .out_data_o  (out_beat),
      .out_ready_i (out_ready)
   );

   assign out_last = out_beat[WIDTH];
   assign out_data = out_beat[WIDTH-1:0];
   assign sel      = sel_q;

endmodule

// File: tb/tb_stream_arb2.sv
// Self-checking bench for stream_arb2: directed scenarios plus a randomized
// run scored against per-source packet queues.
module tb_stream_arb2;

   localparam int unsigned WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in0_valid, in0_last, in0_ready;
   logic [WIDTH-1:0] in0_data;
   logic             in1_valid, in1_last, in1_ready;
   logic [WIDTH-1:0] in1_data;
   logic             out_valid, out_last, out_ready;
   logic [WIDTH-1:0] out_data;
   logic             sel;

   stream_arb2 #(
      .WIDTH (WIDTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in0_valid (in0_valid),
      .in0_data  (in0_data),
      .in0_last  (in0_last),
      .in0_ready (in0_ready),
      .in1_valid (in1_valid),
      .in1_data  (in1_data),
      .in1_last  (in1_last),
      .in1_ready (in1_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ready (out_ready),
      .sel       (sel)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc;

   // Beats are {last, data}.
   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic [8:0] obs[$];
   logic       en0, en1, ordy;

   logic       lg_sel[32], lg_r0[32], lg_r1[32], lg_ov[32], lg_ol[32];
   logic [7:0] lg_od[32];

   // One clock cycle: present queue heads, log state before the edge, retire handshakes.
   task automatic cycle();
      in0_valid = en0 && (q0.size() > 0);
      if (q0.size() > 0) begin
         in0_data = q0[0][7:0];
         in0_last = q0[0][8];
      end
      in1_valid = en1 && (q1.size() > 0);
      if (q1.size() > 0) begin
         in1_data = q1[0][7:0];
         in1_last = q1[0][8];
      end
      out_ready = ordy;
      #1;
      if (cyc < 32) begin
         lg_sel[cyc] = sel;
         lg_r0[cyc]  = in0_ready;
         lg_r1[cyc]  = in1_ready;
         lg_ov[cyc]  = out_valid;
         lg_od[cyc]  = out_data;
         lg_ol[cyc]  = out_last;
      end
      total++;
      if (in0_ready && in1_ready) begin
         bad++;
         $display("FAIL both_ready cyc=%0d: r0=%b r1=%b want not both 1", cyc, in0_ready, in1_ready);
      end
      total++;
      if ((in0_ready || in1_ready) && out_valid && !out_ready) begin
         bad++;
         $display("FAIL ready_when_full cyc=%0d: r0=%b r1=%b want 0 while slot busy",
                  cyc, in0_ready, in1_ready);
      end
      if (out_valid && out_ready) obs.push_back({out_last, out_data});
      if (in0_valid && in0_ready) void'(q0.pop_front());
      if (in1_valid && in1_ready) void'(q1.pop_front());
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      en0       = 1'b0;
      en1       = 1'b0;
      ordy      = 1'b1;
      in0_valid = 1'b0;
      in0_data  = '0;
      in0_last  = 1'b0;
      in1_valid = 1'b0;
      in1_data  = '0;
      in1_last  = 1'b0;
      out_ready = 1'b1;
      q0.delete();
      q1.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cyc   = 0;
      obs.delete();
   endtask

   task automatic test_reset();
      do_reset();
      repeat (10) cycle();
      for (int i = 0; i < 10; i++) begin
         total++;
         if (lg_ov[i] !== 1'b0 || lg_sel[i] !== 1'b0 || lg_r0[i] !== 1'b0 || lg_r1[i] !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle c%0d: ov=%b sel=%b r0=%b r1=%b want all 0",
                     i, lg_ov[i], lg_sel[i], lg_r0[i], lg_r1[i]);
         end
      end
      total++;
      if (out_data !== 8'h00 || out_last !== 1'b0) begin
         bad++;
         $display("FAIL reset_data: data=%h last=%b want 00 0", out_data, out_last);
      end
   endtask

   task automatic test_single();
      bit       e_sel[6] = '{0, 1, 1, 1, 1, 1};
      bit       e_ov[6]  = '{0, 0, 1, 1, 1, 0};
      bit       e_ol[6]  = '{0, 0, 0, 0, 1, 0};
      bit       e_r1[6]  = '{0, 1, 1, 1, 0, 0};
      bit [7:0] e_od[6]  = '{8'h00, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'h00};
      do_reset();
      q1  = '{9'h0A1, 9'h0A2, 9'h1A3};
      en1 = 1'b1;
      repeat (7) cycle();
      for (int i = 0; i < 6; i++) begin
         total++;
         if (lg_sel[i] !== e_sel[i] || lg_ov[i] !== e_ov[i] || lg_r1[i] !== e_r1[i] ||
             (e_ov[i] && (lg_od[i] !== e_od[i] || lg_ol[i] !== e_ol[i]))) begin
            bad++;
            $display("FAIL single c%0d: sel=%b ov=%b r1=%b d=%h l=%b want sel=%b ov=%b r1=%b d=%h l=%b",
                     i, lg_sel[i], lg_ov[i], lg_r1[i], lg_od[i], lg_ol[i],
                     e_sel[i], e_ov[i], e_r1[i], e_od[i], e_ol[i]);
         end
      end
   endtask

   task automatic test_tie();
      logic [8:0] e_obs[$];
      do_reset();
      q0  = '{9'h010, 9'h111};
      q1  = '{9'h020, 9'h121};
      en0 = 1'b1;
      en1 = 1'b1;
      repeat (8) cycle();
      q0 = '{9'h030, 9'h131};
      q1 = '{9'h040, 9'h141};
      repeat (8) cycle();
      total++;
      if (lg_sel[1] !== 1'b0 || lg_r0[1] !== 1'b1 || lg_r1[1] !== 1'b0) begin
         bad++;
         $display("FAIL tie_first: sel=%b r0=%b r1=%b want 0 1 0", lg_sel[1], lg_r0[1], lg_r1[1]);
      end
      total++;
      if (lg_r0[3] !== 1'b0 || lg_r1[3] !== 1'b0) begin
         bad++;
         $display("FAIL tie_gap: r0=%b r1=%b want 0 0", lg_r0[3], lg_r1[3]);
      end
      total++;
      if (lg_sel[4] !== 1'b1 || lg_r1[4] !== 1'b1) begin
         bad++;
         $display("FAIL tie_second: sel=%b r1=%b want 1 1", lg_sel[4], lg_r1[4]);
      end
      total++;
      if (lg_sel[9] !== 1'b0 || lg_r0[9] !== 1'b1 || lg_r1[9] !== 1'b0) begin
         bad++;
         $display("FAIL tie_alternate: sel=%b r0=%b r1=%b want 0 1 0", lg_sel[9], lg_r0[9], lg_r1[9]);
      end
      e_obs = '{9'h010, 9'h111, 9'h020, 9'h121, 9'h030, 9'h131, 9'h040, 9'h141};
      total++;
      if (obs != e_obs) begin
         bad++;
         $display("FAIL tie_order: got %p want %p", obs, e_obs);
      end
   endtask

   task automatic test_backpressure();
      logic [8:0] e_obs[$];
      do_reset();
      q0  = '{9'h055, 9'h066, 9'h177};
      en0 = 1'b1;
      for (int c = 0; c < 12; c++) begin
         ordy = !(c >= 3 && c <= 6);
         cycle();
      end
      for (int i = 3; i <= 6; i++) begin
         total++;
         if (lg_ov[i] !== 1'b1 || lg_od[i] !== 8'h66 || lg_r0[i] !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold c%0d: ov=%b d=%h r0=%b want 1 66 0", i, lg_ov[i], lg_od[i], lg_r0[i]);
         end
      end
      total++;
      if (lg_r0[7] !== 1'b1) begin
         bad++;
         $display("FAIL bp_resume: r0=%b want 1", lg_r0[7]);
      end
      e_obs = '{9'h055, 9'h066, 9'h177};
      total++;
      if (obs != e_obs) begin
         bad++;
         $display("FAIL bp_order: got %p want %p", obs, e_obs);
      end
   endtask

   task automatic test_no_interleave();
      logic [8:0] e_obs[$];
      do_reset();
      q0  = '{9'h001, 9'h002, 9'h003, 9'h104};
      q1  = '{9'h081, 9'h182};
      en0 = 1'b1;
      for (int c = 0; c < 12; c++) begin
         en1 = (c >= 2);
         cycle();
      end
      for (int i = 2; i <= 5; i++) begin
         total++;
         if (lg_r1[i] !== 1'b0) begin
            bad++;
            $display("FAIL noint_hold c%0d: r1=%b want 0", i, lg_r1[i]);
         end
      end
      total++;
      if (lg_r1[6] !== 1'b1 || lg_sel[6] !== 1'b1) begin
         bad++;
         $display("FAIL noint_grant: r1=%b sel=%b want 1 1", lg_r1[6], lg_sel[6]);
      end
      e_obs = '{9'h001, 9'h002, 9'h003, 9'h104, 9'h081, 9'h182};
      total++;
      if (obs != e_obs) begin
         bad++;
         $display("FAIL noint_order: got %p want %p", obs, e_obs);
      end
   endtask

   task automatic test_async_reset();
      logic [8:0] e_obs[$];
      do_reset();
      q0  = '{9'h00A, 9'h00B, 9'h10C};
      en0 = 1'b1;
      repeat (2) cycle();
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'h0A) begin
         bad++;
         $display("FAIL arst_pre: ov=%b d=%h want 1 0a", out_valid, out_data);
      end
      #2;
      rst_n     = 1'b0;
      en0       = 1'b0;
      in0_valid = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 || sel !== 1'b0 ||
          in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
         bad++;
         $display("FAIL arst_clear: ov=%b d=%h l=%b sel=%b r0=%b r1=%b want all 0",
                  out_valid, out_data, out_last, sel, in0_ready, in1_ready);
      end
      q0.delete();
      q1.delete();
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      cyc = 0;
      obs.delete();
      q0  = '{9'h0C1, 9'h1C2};
      q1  = '{9'h0D1, 9'h1D2};
      en0 = 1'b1;
      en1 = 1'b1;
      repeat (9) cycle();
      total++;
      if (lg_sel[1] !== 1'b0 || lg_r0[1] !== 1'b1) begin
         bad++;
         $display("FAIL arst_prio: sel=%b r0=%b want 0 1", lg_sel[1], lg_r0[1]);
      end
      e_obs = '{9'h0C1, 9'h1C2, 9'h0D1, 9'h1D2};
      total++;
      if (obs != e_obs) begin
         bad++;
         $display("FAIL arst_order: got %p want %p", obs, e_obs);
      end
   endtask

   // Random traffic; bit 7 of each beat tags its source so the scoreboard can route it.
   task automatic test_random();
      logic [8:0] exp0[$];
      logic [8:0] exp1[$];
      logic [8:0] b, e;
      logic       cur_src;
      bit         in_pkt;
      int         guard;
      do_reset();
      for (int s = 0; s < 2; s++) begin
         for (int p = 0; p < 10; p++) begin
            int len;
            len = 1 + int'($urandom_range(3));
            for (int j = 0; j < len; j++) begin
               b = {(j == len - 1), s[0], 7'($urandom)};
               if (s == 0) q0.push_back(b);
               else        q1.push_back(b);
            end
         end
      end
      exp0    = q0;
      exp1    = q1;
      in_pkt  = 1'b0;
      cur_src = 1'b0;
      guard   = 0;
      while ((exp0.size() > 0 || exp1.size() > 0) && guard < 3000) begin
         en0  = ($urandom_range(3) != 0);
         en1  = ($urandom_range(3) != 0);
         ordy = ($urandom_range(2) != 0);
         cycle();
         guard++;
         while (obs.size() > 0) begin
            b = obs.pop_front();
            if (b[7] == 1'b0) e = (exp0.size() > 0) ? exp0.pop_front() : 9'hxxx;
            else              e = (exp1.size() > 0) ? exp1.pop_front() : 9'hxxx;
            total++;
            if (b !== e) begin
               bad++;
               $display("FAIL rand_beat: got %h want %h", b, e);
            end
            total++;
            if (in_pkt && b[7] !== cur_src) begin
               bad++;
               $display("FAIL rand_interleave: src=%b want %b", b[7], cur_src);
            end
            cur_src = b[7];
            in_pkt  = !b[8];
         end
      end
      total++;
      if (exp0.size() != 0 || exp1.size() != 0) begin
         bad++;
         $display("FAIL rand_drain: left0=%0d left1=%0d want 0 0", exp0.size(), exp1.size());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_tie();
      test_backpressure();
      test_no_interleave();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
